reg_file_param: RTL
===================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter WIDTH, default 16, data bits per entry; SHALL be legal for any value 1..64.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be legal for any value 2..256, power of two not required.
REQ-003 Parameter AW, default 4, address width; SHALL be at least ceil(log2(DEPTH)).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 we  input  1  write enable, sampled on rising clk.
REQ-007 waddr  input  AW  write address.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 raddr0 / raddr1  input  AW each  read addresses, ports 0 and 1.
REQ-010 rdata0 / rdata1  output  WIDTH each  read data, ports 0 and 1.
REQ-011 clr_req  input  1  request to clear all entries, sampled on rising clk.
REQ-012 clr_busy  output  1  high while the clear sequence is running.
REQ-013 clr_done  output  1  one-cycle pulse when the clear sequence completes.

Function
REQ-014 Write: on rising clk with we=1, clr_busy=0, 0<waddr<DEPTH, entry[waddr] SHALL take wdata; there is no other write path.
REQ-015 Entry 0 SHALL read as all-zeros at all times; writes to address 0 SHALL be discarded.
REQ-016 A write with waddr>=DEPTH SHALL be discarded, with no side effects.
REQ-017 Reads SHALL be combinational with zero-cycle latency: rdataN = entry[raddrN]. Both ports SHALL be independent and may use the same address.
REQ-018 A read with raddrN>=DEPTH SHALL return all-zeros.
REQ-019 Clear FSM states: IDLE, CLEAR, DONE.
REQ-020 IDLE->CLEAR on a rising clk with clr_req=1; the clear index SHALL load 0.
REQ-021 In CLEAR, each cycle SHALL zero entry[index] and increment index. After index DEPTH-1 is zeroed, the FSM SHALL go to DONE; the clear takes exactly DEPTH cycles.
REQ-022 DONE SHALL last one cycle with clr_done=1, then return to IDLE.
REQ-023 clr_busy SHALL be 1 exactly in CLEAR. clr_done SHALL be 1 exactly in DONE.
REQ-024 clr_req SHALL be ignored in CLEAR and DONE; no queuing.
REQ-025 Writes while clr_busy=1 SHALL be discarded. Writes in DONE SHALL be accepted.
REQ-026 we=1 and clr_req=1 on the same edge in IDLE: the write SHALL be performed on that edge, then the clear SHALL overwrite it.
REQ-027 Reads during CLEAR SHALL return current contents: entries already cleared read 0, others keep their old values.

Reset
REQ-028 reset=1 SHALL immediately, independent of clk:
- zero all entries
- force the FSM to IDLE and the index to 0
- drive clr_busy=0 and clr_done=0
REQ-029 reset asserted mid-clear SHALL abort the sequence; no clr_done pulse SHALL follow.
REQ-030 While reset=1, writes and clr_req SHALL have no effect.

Configuration
REQ-031 Macro REG_FILE_BYPASS_EN defined: when the write of REQ-014 is accepted this cycle and raddrN==waddr, rdataN SHALL equal wdata combinationally, on the same cycle.
REQ-032 Macro REG_FILE_BYPASS_EN undefined: rdataN SHALL return the stored value and show the new value only after the write edge. Everything else is identical.

Verification
REQ-033 Reset then read all addresses -> rdata0=rdata1=0x0000 for every address, clr_busy=0, clr_done=0.
REQ-034 Write 0xBEEF to address 5 and 0x1234 to address 0; read raddr0=5, raddr1=0 -> rdata0=0xBEEF, rdata1=0x0000.
REQ-035 Fill entries 1..15 with 0xA5A5; pulse clr_req for one cycle:
- clr_busy high for exactly 16 cycles, then clr_done high for 1 cycle
- all entries then read 0
- a write of 0x7777 to address 3 during busy leaves entry 3 at 0
REQ-036 Assert reset at clear cycle 6 -> clr_busy drops immediately, all entries read 0, no clr_done pulse follows.
REQ-037 Set we=1, waddr=9, wdata=0x5A5A, raddr0=9:
- with REG_FILE_BYPASS_EN: rdata0=0x5A5A in the same cycle
- without REG_FILE_BYPASS_EN: rdata0 keeps the old value until after the edge
REQ-038 With DEPTH=12: write to address 13 has no effect on any entry; a read of address 14 returns 0.

Source files
------------

// File: rtl/reg_file_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_param_if
//  Purpose  : Bundles the write, read, and clear-control signals of
//             reg_file_param into one interface.
//  Ports    : we, waddr, wdata      - write port
//             raddr0/1, rdata0/1    - two independent combinational read ports
//             clr_req               - request a full clear sequence
//             clr_busy, clr_done    - clear status (busy level, done pulse)
//  Modports : master - drives requests (testbench / host side)
//             slave  - register file side
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_file_param_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr0;
    logic [AW-1:0]    raddr1;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;

    modport master (
        output we, waddr, wdata, raddr0, raddr1, clr_req,
        input  rdata0, rdata1, clr_busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, raddr0, raddr1, clr_req,
        output rdata0, rdata1, clr_busy, clr_done
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_param
//  Purpose  : Parameterised register file with one write port, two
//             combinational read ports, a hard-wired zero entry at address 0,
//             and a sequential clear engine (IDLE -> CLEAR -> DONE).
//  Ports    : clk    - rising-edge clock for all state
//             reset  - asynchronous, active-high; zeroes entries, idles FSM
//             bus    - reg_file_param_if.slave (write, read, clear signals)
//  Params   : WIDTH (1..64), DEPTH (2..256), AW (>= ceil(log2(DEPTH)))
//  Options  : REG_FILE_BYPASS_EN - when defined, a write accepted this cycle
//             is forwarded combinationally to a read port addressing it.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    reg_file_param_if.slave bus
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [AW-1:0]    clr_idx;
    logic             clr_busy_q;
    logic             clr_done_q;
    logic             waddr_ok;
    logic             wr_en;

    // Entry 0 is never stored: it always reads as zero.
    logic [WIDTH-1:0] entry [1:DEPTH-1];

    // ------------------------------------------------------------------------
    // Write qualification: only addresses 1..DEPTH-1 are writable, and not
    // while the clear engine is sweeping.
    // ------------------------------------------------------------------------
    always_comb begin
        waddr_ok = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (bus.waddr == AW'(i)) begin
                waddr_ok = 1'b1;
            end
        end
    end

    assign wr_en = bus.we && waddr_ok && (state != S_CLEAR);

    // ------------------------------------------------------------------------
    // Clear FSM with registered status outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            clr_idx    <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.clr_req) begin
                        state      <= S_CLEAR;
                        clr_idx    <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state      <= S_DONE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;

    // ------------------------------------------------------------------------
    // Storage. Clear index 0 targets the unstored zero entry, so that sweep
    // cycle simply does nothing here.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if ((state == S_CLEAR) && (clr_idx == AW'(i))) begin
                    entry[i] <= '0;
                end else if (wr_en && (bus.waddr == AW'(i))) begin
                    entry[i] <= bus.wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports. Addresses 0 and >= DEPTH match no stored entry and fall
    // through to zero.
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                val = entry[i];
            end
        end
`ifdef REG_FILE_BYPASS_EN
        // wr_en already excludes address 0 and out-of-range addresses.
        if (wr_en && (addr == bus.waddr)) begin
            val = bus.wdata;
        end
`endif
        return val;
    endfunction

    always_comb begin
        bus.rdata0 = read_port(bus.raddr0);
        bus.rdata1 = read_port(bus.raddr1);
    end

endmodule
`default_nettype wire
